// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
`endif

   // Even parity: the parity bit equals the XOR of the data bits.
   function automatic logic parity8(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head is presented combinationally, pop advances at the clock edge.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] pushData,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && !empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign doPush = push && (!full || doPop);
   assign head   = empty ? '0 : mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_ONE;
         if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) into a show-ahead FIFO,
// with sticky framing, overrun and parity flags.
import uart_pkg::*;

module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sIn,
   input  logic       dataRen,
   input  logic       errClr,
   output logic [7:0] data,
   output logic       dataValid,
   output logic       fifoFull,
   output logic       frameErr,
   output logic       overrun,
   output logic       parityErr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic                 syncMeta;
   logic                 rxS;
   rx_state_t            state;
   logic [CW-1:0]        baudCnt;
   logic [2:0]           bitIdx;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 bitDone;
   logic                 stopSample;
   logic                 push;
   logic                 empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         syncMeta <= 1'b1;
         rxS      <= 1'b1;
      end else begin
         syncMeta <= sIn;
         rxS      <= syncMeta;
      end
   end

   assign bitDone    = (baudCnt == BIT_LAST);
   assign stopSample = (state == STOP) && bitDone;
   assign push       = stopSample && rxS;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxS) begin
                  baudCnt <= '0;
                  state   <= START;
               end
            end
            // Re-check the start bit at its middle so every later sample lands mid-bit.
            START: begin
               if (baudCnt == HALF_LAST) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  state   <= rxS ? IDLE : DATA;
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            DATA: begin
               if (bitDone) begin
                  baudCnt  <= '0;
                  shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                  bitIdx   <= bitIdx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bitIdx == 3'd7) state <= PARITY;
`else
                  if (bitIdx == 3'd7) state <= STOP;
`endif
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bitDone) begin
                  baudCnt <= '0;
                  state   <= STOP;
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
`endif
            STOP: begin
               if (bitDone) begin
                  baudCnt <= '0;
                  state   <= rxS ? IDLE : BREAK;
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            BREAK: begin
               if (rxS) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Set events take priority over a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frameErr <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (stopSample && !rxS) frameErr <= 1'b1;
         else if (errClr)        frameErr <= 1'b0;
         if (push && fifoFull && !dataRen) overrun <= 1'b1;
         else if (errClr)                  overrun <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic paritySet;
   assign paritySet = (state == PARITY) && bitDone && (rxS != parity8(shiftReg));

   always_ff @(posedge clk) begin
      if (!rst)           parityErr <= 1'b0;
      else if (paritySet) parityErr <= 1'b1;
      else if (errClr)    parityErr <= 1'b0;
   end
`else
   assign parityErr = 1'b0;
`endif

   uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (DATA_BITS)
   ) rxFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (dataRen),
      .pushData (shiftReg),
      .head     (data),
      .full     (fifoFull),
      .empty    (empty)
   );

   assign dataValid = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       sIn     = 1'b1;
   logic       dataRen = 1'b0;
   logic       errClr  = 1'b0;
   logic [7:0] data;
   logic       dataValid;
   logic       fifoFull;
   logic       frameErr;
   logic       overrun;
   logic       parityErr;

   int testCount = 0;
   int failCount = 0;

`ifdef UART_RX_PARITY_EN
   logic badParity = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sIn       (sIn),
      .dataRen   (dataRen),
      .errClr    (errClr),
      .data      (data),
      .dataValid (dataValid),
      .fifoFull  (fifoFull),
      .frameErr  (frameErr),
      .overrun   (overrun),
      .parityErr (parityErr)
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drives one frame; leaves sIn at the stop-bit level. popAtStop pulses dataRen
   // in exactly the cycle whose closing edge samples the stop bit (push edge).
   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input bit popAtStop);
      @(posedge clk); #1 sIn = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 sIn = b[i];
         repeat (CPB) @(posedge clk);
      end
`ifdef UART_RX_PARITY_EN
      #1 sIn = (^b) ^ badParity;
      repeat (CPB) @(posedge clk);
`endif
      #1 sIn = stopBit;
      if (popAtStop) begin
         repeat (10) @(posedge clk);
         #1 dataRen = 1'b1;
         @(posedge clk);
         #1 dataRen = 1'b0;
         repeat (5) @(posedge clk);
      end else begin
         repeat (CPB) @(posedge clk);
      end
      #1;
   endtask

   task automatic popCheck(input string tag, input logic [7:0] exp);
      checkEq(tag, data, exp);
      dataRen = 1'b1;
      @(posedge clk);
      #1 dataRen = 1'b0;
   endtask

   task automatic pulseErrClr();
      errClr = 1'b1;
      @(posedge clk);
      #1 errClr = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkEq("rst data", data, 8'h00);
      checkEq("rst dataValid", dataValid, 1'b0);
      checkEq("rst fifoFull", fifoFull, 1'b0);
      checkEq("rst frameErr", frameErr, 1'b0);
      checkEq("rst overrun", overrun, 1'b0);
      checkEq("rst parityErr", parityErr, 1'b0);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Single byte
      sendFrame(8'hA5, 1'b1, 1'b0);
      checkEq("a5 dataValid", dataValid, 1'b1);
      popCheck("a5 data", 8'hA5);
      checkEq("a5 popped dataValid", dataValid, 1'b0);
      checkEq("a5 popped data", data, 8'h00);

      // Short low glitch must not start a frame
      sIn = 1'b0;
      repeat (6) @(posedge clk);
      #1 sIn = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkEq("glitch dataValid", dataValid, 1'b0);
      checkEq("glitch frameErr", frameErr, 1'b0);
      checkEq("glitch overrun", overrun, 1'b0);

      // Stop bit low, then line held low (break)
      sendFrame(8'h3C, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      checkEq("break frameErr", frameErr, 1'b1);
      checkEq("break dataValid", dataValid, 1'b0);
      sIn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkEq("break released dataValid", dataValid, 1'b0);
      checkEq("break frameErr sticky", frameErr, 1'b1);
      pulseErrClr();
      checkEq("errClr frameErr", frameErr, 1'b0);
      sendFrame(8'h5A, 1'b1, 1'b0);
      popCheck("after break data", 8'h5A);

      // Nine bytes without popping: ninth is dropped
      for (int b = 1; b <= 9; b++) sendFrame(8'(b), 1'b1, 1'b0);
      checkEq("ovr fifoFull", fifoFull, 1'b1);
      checkEq("ovr overrun", overrun, 1'b1);
      for (int b = 1; b <= 8; b++) popCheck($sformatf("ovr pop %0d", b), 8'(b));
      checkEq("ovr drained dataValid", dataValid, 1'b0);
      checkEq("ovr drained fifoFull", fifoFull, 1'b0);
      dataRen = 1'b1;
      @(posedge clk);
      #1 dataRen = 1'b0;
      checkEq("empty pop dataValid", dataValid, 1'b0);
      pulseErrClr();
      checkEq("errClr overrun", overrun, 1'b0);

      // Full FIFO, pop coincides with the ninth push
      for (int b = 1; b <= 8; b++) sendFrame(8'(b), 1'b1, 1'b0);
      checkEq("fullpop pre fifoFull", fifoFull, 1'b1);
      sendFrame(8'h09, 1'b1, 1'b1);
      checkEq("fullpop overrun", overrun, 1'b0);
      checkEq("fullpop fifoFull", fifoFull, 1'b1);
      for (int b = 2; b <= 9; b++) popCheck($sformatf("fullpop pop %0d", b), 8'(b));
      checkEq("fullpop drained dataValid", dataValid, 1'b0);

      // Pop and push together while empty: push lands, pop ignored
      sendFrame(8'h77, 1'b1, 1'b1);
      checkEq("emptypop dataValid", dataValid, 1'b1);
      popCheck("emptypop data", 8'h77);
      checkEq("emptypop drained", dataValid, 1'b0);

`ifdef UART_RX_PARITY_EN
      badParity = 1'b0;
      sendFrame(8'h07, 1'b1, 1'b0);
      checkEq("par good parityErr", parityErr, 1'b0);
      popCheck("par good data", 8'h07);
      badParity = 1'b1;
      sendFrame(8'h07, 1'b1, 1'b0);
      badParity = 1'b0;
      checkEq("par bad parityErr", parityErr, 1'b1);
      checkEq("par bad dataValid", dataValid, 1'b1);
      popCheck("par bad data", 8'h07);
      pulseErrClr();
      checkEq("errClr parityErr", parityErr, 1'b0);
`endif

      // Reset in the middle of a frame flushes the FIFO and the partial byte
      sendFrame(8'hE1, 1'b1, 1'b0);
      checkEq("mid pre dataValid", dataValid, 1'b1);
      sIn = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      sIn = 1'b1;
      checkEq("mid rst dataValid", dataValid, 1'b0);
      checkEq("mid rst data", data, 8'h00);
      repeat (40) @(posedge clk);
      #1;
      checkEq("mid rst later dataValid", dataValid, 1'b0);
      checkEq("mid rst frameErr", frameErr, 1'b0);
      sendFrame(8'hC3, 1'b1, 1'b0);
      popCheck("mid rst recover data", 8'hC3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
